// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// Build option: define MULT_RADIX4_EN for radix-4 recoding (16 steps);
// leave it undefined for radix-2 recoding (32 steps).
package mult_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Booth partial-product selection
    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_ADD1 = 3'd1,
        OP_ADD2 = 3'd2,
        OP_SUB1 = 3'd3,
        OP_SUB2 = 3'd4
    } booth_op_e;

`ifdef MULT_RADIX4_EN
    localparam int unsigned ITER  = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = 34;
    localparam int unsigned GRP_W = 3;
    localparam int unsigned SHIFT = 2;
`else
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned ACC_W = 33;
    localparam int unsigned GRP_W = 2;
    localparam int unsigned SHIFT = 1;
`endif

endpackage

// File: rtl/booth_recode.sv
// Combinational Booth group decoder: maps the low multiplier bits plus the
// previously shifted-out bit to a partial-product selection.
// Build option: MULT_RADIX4_EN selects the 3-bit (radix-4) group decoder.
module booth_recode
    import mult_pkg::*;
(
    input  logic [GRP_W-1:0] grp,
    output booth_op_e        op
);

    // Group decode
    always_comb begin
        op = OP_ZERO;
`ifdef MULT_RADIX4_EN
        case (grp)
            3'b001, 3'b010: op = OP_ADD1;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB1;
            default:        op = OP_ZERO;
        endcase
`else
        case (grp)
            2'b01:   op = OP_ADD1;
            2'b10:   op = OP_SUB1;
            default: op = OP_ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/booth_multiply.sv
// Sequential signed 32x32 Booth multiplier with start / ready / exception
// handshake. Returns the low 32 bits of the product and flags signed overflow.
// Build option: MULT_RADIX4_EN selects radix-4 (ready in cycle 17); default
// is radix-2 (ready in cycle 33). Results are identical in both builds.
module booth_multiply
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] mult_result,
    output logic        ready,
    output logic        exception
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      p_q, p_d;
    logic             qm1_q, qm1_d;
    logic [31:0]      res_q, res_d;
    logic             exc_q, exc_d;

    logic [GRP_W-1:0] grp;
    booth_op_e        op;

    logic [ACC_W-1:0]          a_ext, sel, addend, sum;
    logic                      neg;
    logic signed [ACC_W+32:0]  cat, shr;
    logic [63:0]               prod;
    logic                      ovf;

`ifdef MULT_RADIX4_EN
    assign grp = {p_q[1], p_q[0], qm1_q};
`else
    assign grp = {p_q[0], qm1_q};
`endif

    booth_recode u_recode (
        .grp (grp),
        .op  (op)
    );

    // One Booth step: select multiple of A, add (negation via invert + carry-in), shift
    always_comb begin
        a_ext  = {{(ACC_W-32){a_q[31]}}, a_q};
        sel    = '0;
        neg    = 1'b0;
        case (op)
            OP_ADD1: sel = a_ext;
            OP_ADD2: sel = a_ext << 1;
            OP_SUB1: begin sel = a_ext;      neg = 1'b1; end
            OP_SUB2: begin sel = a_ext << 1; neg = 1'b1; end
            default: sel = '0;
        endcase
        addend = neg ? ~sel : sel;
        sum    = acc_q + addend + {{(ACC_W-1){1'b0}}, neg};
        cat    = {sum, p_q, qm1_q};
        shr    = cat >>> SHIFT;
        prod   = {shr[64:33], shr[32:1]};
        ovf    = ~((&prod[63:31]) | ~(|prod[63:31]));
    end

    // Next-state, counter and datapath control; a start pulse always reloads
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        p_d     = p_q;
        qm1_d   = qm1_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            ST_RUN: begin
                acc_d = shr[ACC_W+32:33];
                p_d   = shr[32:1];
                qm1_d = shr[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_DONE;
                    res_d   = prod[31:0];
                    exc_d   = ovf;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (ctrl_mult) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            a_d     = multiplicand;
            acc_d   = '0;
            p_d     = multiplier;
            qm1_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            qm1_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            qm1_q   <= qm1_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign ready       = (state_q == ST_DONE);
    assign mult_result = res_q;
    assign exception   = exc_q;

endmodule

// File: tb/tb_booth_multiply.sv
// Self-checking bench for booth_multiply against a plain-arithmetic product model.
// Build option: MULT_RADIX4_EN must match the RTL build (sets expected latency).
module tb_booth_multiply;

`ifdef MULT_RADIX4_EN
    localparam int ITER = 16;
`else
    localparam int ITER = 32;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_mult;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] mult_result;
    logic        ready;
    logic        exception;

    int checks = 0;
    int errors = 0;

    booth_multiply dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_mult    (ctrl_mult),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mult_result  (mult_result),
        .ready        (ready),
        .exception    (exception)
    );

    always #5 clk = ~clk;

    // Reference: full signed product by ordinary 64-bit arithmetic
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        pa = longint'($signed(a)) * longint'($signed(b));
        return pa;
    endfunction

    function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = ref_prod(a, b);
        return !(p[63:31] == '0 || p[63:31] == '1);
    endfunction

    // Start an operation, watch the following cycles, and check the result
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name);
        int n_rdy = 0;
        int rdy_at = -1;
        logic [31:0] r_at = 'x;
        logic e_at = 1'bx;
        logic [31:0] exp_r;
        logic exp_e;
        logic [63:0] p;
        p = ref_prod(a, b);
        exp_r = p[31:0];
        exp_e = ref_exc(a, b);
        @(negedge clk);
        ctrl_mult = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        ctrl_mult = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        for (int k = 1; k <= ITER + 4; k++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                n_rdy++; rdy_at = k; r_at = mult_result; e_at = exception;
            end
        end
        checks++;
        if (n_rdy !== 1 || rdy_at !== ITER) begin
            errors++;
            $display("FAIL %s ready: pulses=%0d at cycle %0d, required 1 at cycle %0d", name, n_rdy, rdy_at, ITER + 1);
        end
        checks++;
        if (r_at !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, r_at, exp_r);
        end
        checks++;
        if (e_at !== exp_e) begin
            errors++;
            $display("FAIL %s exception: got %b required %b", name, e_at, exp_e);
        end
        checks++;
        if (mult_result !== exp_r || exception !== exp_e) begin
            errors++;
            $display("FAIL %s hold: got %h/%b required %h/%b", name, mult_result, exception, exp_r, exp_e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_mult = 1'b1; multiplicand = 32'd3; multiplier = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mult_result !== 32'd0 || ready !== 1'b0 || exception !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%b required 0/0/0", mult_result, ready, exception);
        end
        reset = 1'b0; ctrl_mult = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_override: ready=%b at cycle %0d required 0", ready, k);
            end
        end
    endtask

    task automatic test_directed();
        run_op(32'd3, 32'd7, "3x7");
        run_op(-32'sd5, 32'd6, "m5x6");
        run_op(-32'sd5, -32'sd6, "m5xm6");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "minxm1");
        run_op(32'h8000_0000, 32'd1, "minx1");
        run_op(32'h0001_0000, 32'h0001_0000, "2p16sq");
        run_op(32'h8000_0000, 32'h8000_0000, "minxmin");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxxmax");
        run_op(32'd0, 32'hDEAD_BEEF, "zero");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) a = $signed(a) >>> $urandom_range(31, 14);
            if (i % 3 == 2) b = $signed(b) >>> $urandom_range(31, 14);
            run_op(a, b, $sformatf("rand%0d", i));
        end
    endtask

    // Restart in cycle 5 of a running operation; the first op must never complete
    task automatic test_back_to_back();
        int early = 0;
        @(negedge clk);
        ctrl_mult = 1'b1; multiplicand = 32'd100; multiplier = 32'd100;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) early++;
        end
        ctrl_mult = 1'b1; multiplicand = 32'd12; multiplier = 32'd12;
        @(posedge clk); #1;
        checks++;
        if (early !== 0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: early=%0d ready=%b required 0/0", early, ready);
        end
        ctrl_mult = 1'b0;
        for (int k = 1; k <= ITER + 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== (k == ITER)) begin
                errors++;
                $display("FAIL restart_ready: ready=%b at cycle %0d required %b", ready, k + 1, (k == ITER));
            end
            if (k == ITER) begin
                checks++;
                if (mult_result !== 32'h0000_0090 || exception !== 1'b0) begin
                    errors++;
                    $display("FAIL restart_result: got %h/%b required 00000090/0", mult_result, exception);
                end
            end
        end
        // consecutive start pulses: only the last operation completes
        run_op(32'd9, 32'd9, "prime");
        @(negedge clk);
        ctrl_mult = 1'b1; multiplicand = 32'd1000; multiplier = 32'd1000;
        @(posedge clk); #1;
        multiplicand = -32'sd4; multiplier = 32'd11;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        for (int k = 1; k <= ITER + 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== (k == ITER)) begin
                errors++;
                $display("FAIL consec_ready: ready=%b at cycle %0d required %b", ready, k + 1, (k == ITER));
            end
        end
        checks++;
        if (mult_result !== 32'hFFFF_FFD4) begin
            errors++;
            $display("FAIL consec_result: got %h required ffffffd4", mult_result);
        end
    endtask

    // Reset asserted in cycle 8 of an operation, then a fresh operation
    task automatic test_reset_mid();
        run_op(32'hFFFF_0000, 32'h0001_0000, "pre_reset");
        @(negedge clk);
        ctrl_mult = 1'b1; multiplicand = 32'd123; multiplier = 32'd456;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (mult_result !== 32'd0 || exception !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: got %h/%b/%b required 0/0/0", mult_result, exception, ready);
        end
        for (int k = 0; k < ITER + 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0 || mult_result !== 32'd0) begin
                errors++;
                $display("FAIL mid_reset_idle: ready=%b result=%h at cycle %0d required 0/0", ready, mult_result, k);
            end
        end
        run_op(32'd123, 32'd456, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
